// File: rtl/multi_clk_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multi_clk_divider
//
// Multi-channel clock divider / tick generator. Each channel counts
// 0..div_active-1 while enabled. On the terminal count (TC) it emits a
// one-cycle tick and toggles a 50%-duty divided clock. Divisor writes to a
// running channel are held pending and applied at that channel's TC, so the
// output never sees a shortened or stretched period.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-low reset
//   en_i        per-channel run enable
//   sync_i      single-cycle restart of all enabled channels
//   cfg_we_i    divisor write strobe
//   cfg_ch_i    target channel of the write
//   cfg_div_i   new divisor value (0 is rejected)
//   cfg_err_o   one-cycle pulse: the previous write was rejected
//   pending_o   per-channel: divisor written, not yet applied
//   tick_o      per-channel one-cycle pulse every div_active cycles
//   slow_clk_o  per-channel divided clock, period 2*div_active
// -----------------------------------------------------------------------------
module multi_clk_divider #(
    parameter int unsigned  NUM_CH      = 4,
    parameter int unsigned  CNT_W       = 32,
    parameter int unsigned  DEFAULT_DIV = 27000,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic              cfg_err_o,
    output logic [NUM_CH-1:0] pending_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] slow_clk_o
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] div_active_q, div_active_d;
    logic [NUM_CH-1:0][CNT_W-1:0] div_pend_q, div_pend_d;
    logic [NUM_CH-1:0]            pending_q, pending_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            slow_q, slow_d;
    logic                         cfg_err_q, cfg_err_d;

    logic              ch_oob;
    logic              cfg_bad;
    logic              cfg_ok;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] tc;

    // A channel index can only be out of range when NUM_CH is not a power of
    // two; otherwise every encodable index is a real channel.
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_ch_full
            assign ch_oob = 1'b0;
        end else begin : g_ch_part
            assign ch_oob = (cfg_ch_i >= CH_W'(NUM_CH));
        end
    endgenerate

    assign cfg_bad   = cfg_we_i && ((cfg_div_i == '0) || ch_oob);
    assign cfg_ok    = cfg_we_i && !cfg_bad;
    assign cfg_err_d = cfg_bad;

    // div_active is never 0 (reset value >= 1, zero writes rejected), so
    // div_active-1 cannot wrap.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_sel[ch] = cfg_ok && (cfg_ch_i == CH_W'(ch));
            tc[ch]     = (cnt_q[ch] == div_active_q[ch] - ONE);
        end
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no
        // branch below can leave one unassigned and infer a latch.
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        div_pend_d   = div_pend_q;
        pending_d    = pending_q;
        tick_d       = tick_q;
        slow_d       = slow_q;

        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!en_i[ch]) begin
                // Idle: parked at the start of a period; writes apply at once.
                cnt_d[ch]  = '0;
                tick_d[ch] = 1'b0;
                slow_d[ch] = 1'b0;
                if (wr_sel[ch]) begin
                    div_active_d[ch] = cfg_div_i;
                    pending_d[ch]    = 1'b0;
                end
            end else if (sync_i) begin
                // Restart: a same-cycle write beats an older pending value.
                cnt_d[ch]  = '0;
                tick_d[ch] = 1'b0;
                slow_d[ch] = 1'b0;
                if (wr_sel[ch]) begin
                    div_active_d[ch] = cfg_div_i;
                end else if (pending_q[ch]) begin
                    div_active_d[ch] = div_pend_q[ch];
                end
                pending_d[ch] = 1'b0;
            end else if (tc[ch]) begin
                // Period boundary: the only safe point to swap the divisor.
                cnt_d[ch]  = '0;
                tick_d[ch] = 1'b1;
                slow_d[ch] = ~slow_q[ch];
                if (wr_sel[ch]) begin
                    div_active_d[ch] = cfg_div_i;
                end else if (pending_q[ch]) begin
                    div_active_d[ch] = div_pend_q[ch];
                end
                pending_d[ch] = 1'b0;
            end else begin
                cnt_d[ch]  = cnt_q[ch] + ONE;
                tick_d[ch] = 1'b0;
                if (wr_sel[ch]) begin
                    div_pend_d[ch] = cfg_div_i;
                    pending_d[ch]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the divisor banks are flops, not RAM, and their values are
            // visible through timing, so they are reset along with the rest.
            cnt_q        <= '0;
            div_active_q <= {NUM_CH{DEF_DIV}};
            div_pend_q   <= {NUM_CH{DEF_DIV}};
            pending_q    <= '0;
            tick_q       <= '0;
            slow_q       <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values, independent of statement order.
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            div_pend_q   <= div_pend_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            slow_q       <= slow_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_err_o  = cfg_err_q;
    assign pending_o  = pending_q;
    assign tick_o     = tick_q;
    assign slow_clk_o = slow_q;

endmodule

// File: tb/tb_multi_clk_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_multi_clk_divider
//
// Bench for multi_clk_divider. A schedule-based reference model (absolute
// edge number of each channel's next terminal count) is compared against the
// DUT on every falling edge; directed sequences, a vector table and a random
// phase drive the stimulus. A second 3-channel instance exercises the
// out-of-range channel rejection.
// -----------------------------------------------------------------------------
module tb_multi_clk_divider;

    localparam int NCH = 4;
    localparam int DEF = 27000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  en;
    logic            sync;
    logic            cfg_we;
    logic [1:0]      cfg_ch;
    logic [31:0]     cfg_div;
    logic            cfg_err;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  tick_o;
    logic [NCH-1:0]  slow_clk;

    logic [2:0]      en3;
    logic            sync3;
    logic            cfg3_we;
    logic [1:0]      cfg3_ch;
    logic [31:0]     cfg3_div;
    logic            err3;
    logic [2:0]      pending3;
    logic [2:0]      tick3;
    logic [2:0]      slow3;

    int n_checks = 0;
    int n_pass   = 0;
    bit mdl_on   = 1'b0;

    always #5 clk = ~clk;

    multi_clk_divider #(.NUM_CH(NCH), .CNT_W(32), .DEFAULT_DIV(DEF)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .sync_i     (sync),
        .cfg_we_i   (cfg_we),
        .cfg_ch_i   (cfg_ch),
        .cfg_div_i  (cfg_div),
        .cfg_err_o  (cfg_err),
        .pending_o  (pending),
        .tick_o     (tick_o),
        .slow_clk_o (slow_clk)
    );

    multi_clk_divider #(.NUM_CH(3), .CNT_W(32), .DEFAULT_DIV(2)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en3),
        .sync_i     (sync3),
        .cfg_we_i   (cfg3_we),
        .cfg_ch_i   (cfg3_ch),
        .cfg_div_i  (cfg3_div),
        .cfg_err_o  (err3),
        .pending_o  (pending3),
        .tick_o     (tick3),
        .slow_clk_o (slow3)
    );

    // ------------------------------------------------------------------
    // Reference model: each channel knows the absolute edge number of its
    // next terminal count; restarts reschedule it to "now + divisor".
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [63:0] nxt_tc;
        logic [31:0] div;
        logic [31:0] pdiv;
        logic        pend;
        logic        tick;
        logic        slow;
    } ch_st_t;

    ch_st_t      mdl [NCH];
    logic        mdl_err = 1'b0;
    logic [63:0] edge_n  = '0;

    function automatic ch_st_t chan_next(input ch_st_t s, input logic rst_v,
                                         input logic en_v, input logic sync_v,
                                         input logic wr_v, input logic [31:0] cfg_v,
                                         input logic [63:0] n);
        ch_st_t r = s;
        if (!rst_v) begin
            r.div = DEF; r.pdiv = DEF; r.pend = 1'b0;
            r.tick = 1'b0; r.slow = 1'b0; r.nxt_tc = n + DEF;
        end else if (!en_v) begin
            r.tick = 1'b0; r.slow = 1'b0;
            if (wr_v) begin r.div = cfg_v; r.pend = 1'b0; end
            r.nxt_tc = n + 64'(r.div);
        end else if (sync_v || n == s.nxt_tc) begin
            r.tick = !sync_v;
            r.slow = sync_v ? 1'b0 : !s.slow;
            if (wr_v)        r.div = cfg_v;
            else if (s.pend) r.div = s.pdiv;
            r.pend   = 1'b0;
            r.nxt_tc = n + 64'(r.div);
        end else begin
            r.tick = 1'b0;
            if (wr_v) begin r.pdiv = cfg_v; r.pend = 1'b1; end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        edge_n  <= edge_n + 1;
        mdl_err <= rst && cfg_we && (cfg_div == 0 || int'(cfg_ch) >= NCH);
        for (int c = 0; c < NCH; c++)
            mdl[c] <= chan_next(mdl[c], rst, en[c], sync,
                                rst && cfg_we && cfg_div != 0 && int'(cfg_ch) == c,
                                cfg_div, edge_n + 1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic [NCH-1:0] et, es, ep;
        if (mdl_on) begin
            for (int c = 0; c < NCH; c++) begin
                et[c] = mdl[c].tick;
                es[c] = mdl[c].slow;
                ep[c] = mdl[c].pend;
            end
            check("model {err,pend,tick,slow}",
                  64'({cfg_err, pending, tick_o, slow_clk}), 64'({mdl_err, ep, et, es}));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Steps until tick_o[c] is seen or the limit expires; returns step count.
    task automatic wait_tick(input int c, input int limit, input string name, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!tick_o[c] && cnt < limit);
        check({name, " tick seen"}, 64'(tick_o[c]), 64'(1));
    endtask

    // ------------------------------------------------------------------
    // Vector table: {inputs} -> {expected outputs}, one clock each.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0]  en;
        logic        sync;
        logic        we;
        logic [1:0]  ch;
        logic [31:0] div;
        logic [3:0]  e_tick;
        logic [3:0]  e_slow;
        logic [3:0]  e_pend;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int first [NCH];
        int exp_first [NCH];

        // ch2 at div=1, rejected zero write, ch3 pending / TC-collision / sync cases
        tbl[0]  = '{4'b0000, 1'b0, 1'b1, 2'd2, 32'd1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0100, 4'b0100, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0100, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 32'd0, 4'b0100, 4'b0100, 4'b0000, 1'b1};
        tbl[4]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0100, 4'b0000, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 32'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[8]  = '{4'b1000, 1'b0, 1'b1, 2'd3, 32'd2, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[9]  = '{4'b1000, 1'b0, 1'b1, 2'd3, 32'd4, 4'b1000, 4'b1000, 4'b0000, 1'b0};
        tbl[10] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b1000, 4'b0000, 1'b0};
        tbl[11] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b1000, 4'b0000, 1'b0};
        tbl[12] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b1000, 4'b0000, 1'b0};
        tbl[13] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b1000, 4'b0000, 4'b0000, 1'b0};
        tbl[14] = '{4'b1000, 1'b0, 1'b1, 2'd3, 32'd2, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        tbl[15] = '{4'b1000, 1'b1, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[16] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[17] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b1000, 4'b1000, 4'b0000, 1'b0};
        tbl[18] = '{4'b1000, 1'b1, 1'b1, 2'd3, 32'd3, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[19] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[20] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[21] = '{4'b1000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b1000, 4'b1000, 4'b0000, 1'b0};
        tbl[22] = '{4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000, 4'b0000, 4'b0000, 1'b0};

        rst = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        en3 = '0; sync3 = 1'b0; cfg3_we = 1'b0; cfg3_ch = '0; cfg3_div = '0;

        // ---- reset state ----
        step();
        mdl_on = 1'b1;
        step();
        check("reset tick", 64'(tick_o), 64'(0));
        check("reset slow_clk", 64'(slow_clk), 64'(0));
        check("reset pending", 64'(pending), 64'(0));
        check("reset cfg_err", 64'(cfg_err), 64'(0));

        // ---- ch0 at the default divisor: first tick DEF cycles after start ----
        rst = 1'b1; en = 4'b0001;
        wait_tick(0, DEF + 100, "ch0 default", k);
        check("ch0 first tick latency", 64'(k), 64'(DEF));
        check("ch0 slow_clk rises with tick", 64'(slow_clk[0]), 64'(1));
        check("ch1..3 idle tick", 64'(tick_o[3:1]), 64'(0));
        check("ch1..3 idle slow_clk", 64'(slow_clk[3:1]), 64'(0));
        step();
        check("ch0 tick one cycle only", 64'(tick_o[0]), 64'(0));
        en = '0;
        step();

        // ---- ch1 divisor change while running ----
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd10;
        step();
        cfg_we = 1'b0;
        check("disabled write not pending", 64'(pending), 64'(0));
        en = 4'b0010;
        repeat (4) step();
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd5;
        step();
        cfg_we = 1'b0;
        check("ch1 pending after write", 64'(pending), 64'(4'b0010));
        wait_tick(1, 20, "ch1 old period", k);
        check("ch1 old period completes", 64'(k), 64'(5));
        check("ch1 pending clears at TC", 64'(pending[1]), 64'(0));
        wait_tick(1, 20, "ch1 new period", k);
        check("ch1 new period 5", 64'(k), 64'(5));

        // ---- rejected writes ----
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd0;
        step();
        cfg_we = 1'b0;
        check("zero div cfg_err", 64'(cfg_err), 64'(1));
        check("zero div no pending", 64'(pending), 64'(0));
        step();
        check("cfg_err one cycle", 64'(cfg_err), 64'(0));
        wait_tick(1, 20, "ch1 phase", k);
        wait_tick(1, 20, "ch1 after bad write", k);
        check("ch1 divisor unchanged", 64'(k), 64'(5));
        cfg3_we = 1'b1; cfg3_ch = 2'd3; cfg3_div = 32'd5;
        step();
        cfg3_we = 1'b0;
        check("ch==NUM_CH cfg_err", 64'(err3), 64'(1));
        check("ch==NUM_CH no pending", 64'(pending3), 64'(0));
        step();
        check("ch==NUM_CH cfg_err one cycle", 64'(err3), 64'(0));
        cfg3_we = 1'b1; cfg3_ch = 2'd2; cfg3_div = 32'd5;
        step();
        cfg3_we = 1'b0;
        check("valid ch2 no cfg_err", 64'(err3), 64'(0));
        en = '0;
        step();

        // ---- vector table ----
        for (int i = 0; i < NVEC; i++) begin
            en = tbl[i].en; sync = tbl[i].sync;
            cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_div = tbl[i].div;
            step();
            check($sformatf("vec%0d tick", i), 64'(tick_o), 64'(tbl[i].e_tick));
            check($sformatf("vec%0d slow_clk", i), 64'(slow_clk), 64'(tbl[i].e_slow));
            check($sformatf("vec%0d pending", i), 64'(pending), 64'(tbl[i].e_pend));
            check($sformatf("vec%0d cfg_err", i), 64'(cfg_err), 64'(tbl[i].e_err));
        end
        sync = 1'b0; cfg_we = 1'b0;

        // ---- sync restart of channels at 3,4,6,7 ----
        exp_first = '{3, 4, 6, 7};
        for (int c = 0; c < NCH; c++) begin
            cfg_we = 1'b1; cfg_ch = 2'(c); cfg_div = 32'(exp_first[c]);
            step();
        end
        cfg_we = 1'b0;
        en = 4'b1111;
        repeat ($urandom_range(5, 20)) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync clears tick", 64'(tick_o), 64'(0));
        check("sync clears slow_clk", 64'(slow_clk), 64'(0));
        first = '{0, 0, 0, 0};
        for (int s = 1; s <= 8; s++) begin
            step();
            for (int c = 0; c < NCH; c++)
                if (first[c] == 0 && tick_o[c]) first[c] = s;
        end
        for (int c = 0; c < NCH; c++)
            check($sformatf("ch%0d first tick after sync", c), 64'(first[c]), 64'(exp_first[c]));

        // ---- reset mid-period with a pending divisor ----
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 32'd2;
        step();
        cfg_we = 1'b0;
        check("pending before reset", 64'(pending), 64'(4'b0010));
        rst = 1'b0; en = 4'b0010;
        step();
        check("reset clears pending", 64'(pending), 64'(0));
        check("reset clears tick", 64'(tick_o), 64'(0));
        check("reset clears slow_clk", 64'(slow_clk), 64'(0));
        rst = 1'b1;
        wait_tick(1, DEF + 100, "ch1 after reset", k);
        check("divisor back to default", 64'(k), 64'(DEF));

        // ---- random stimulus against the model ----
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = 4'($urandom);
            sync    = ($urandom_range(0, 39) == 0);
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_ch  = 2'($urandom);
            cfg_div = 32'($urandom_range(0, 8));
            rst     = !($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b1; cfg_we = 1'b0; sync = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
